// File: rtl/pipelined_accum_adder_tree_if.sv
// Bundles the beat input and result output handshakes of the pipelined accumulating adder tree.
// slave is the block's own view, master is the view of whoever drives it.
interface pipelined_accum_adder_tree_if #(
  parameter int INPUT_NUM = 8,
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = IN_WIDTH + $clog2(INPUT_NUM) + 8,
  parameter int CNT_WIDTH = 8
);
  logic                                in_valid;
  logic                                in_ready;
  logic [INPUT_NUM-1:0][IN_WIDTH-1:0]  in_data;
  logic                                in_last;
  logic                                in_acc_en;
  logic                                out_valid;
  logic                                out_ready;
  logic signed [ACC_WIDTH-1:0]         out_data;
  logic [CNT_WIDTH-1:0]                out_beats;

  modport master (
    output in_valid, in_data, in_last, in_acc_en, out_ready,
    input  in_ready, out_valid, out_data, out_beats
  );

  modport slave (
    input  in_valid, in_data, in_last, in_acc_en, out_ready,
    output in_ready, out_valid, out_data, out_beats
  );
endinterface

// File: rtl/pipelined_accum_adder_tree.sv
// Signed pipelined reduction tree over INPUT_NUM operands per beat, followed by an
// optional accumulator that folds a group of beats into one result, with global stall.
module pipelined_accum_adder_tree #(
  parameter int INPUT_NUM  = 8,
  parameter int IN_WIDTH   = 16,
  parameter int STAGE_NUM  = $clog2(INPUT_NUM),
  parameter int TREE_WIDTH = IN_WIDTH + STAGE_NUM,
  parameter int ACC_WIDTH  = TREE_WIDTH + 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  pipelined_accum_adder_tree_if.slave   bus
);

  typedef enum logic {EMPTY, PARTIAL} acc_state_e;

  function automatic int lvl_cnt(input int k);
    int n;
    n = INPUT_NUM;
    for (int i = 0; i < k; i++) n = (n + 1) / 2;
    return n;
  endfunction

  function automatic logic signed [TREE_WIDTH-1:0] sext_in(input logic [IN_WIDTH-1:0] x);
    return {{STAGE_NUM{x[IN_WIDTH-1]}}, x};
  endfunction

  function automatic logic signed [ACC_WIDTH-1:0] sext_acc(input logic signed [TREE_WIDTH-1:0] x);
    return ACC_WIDTH'(x);
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + CNT_WIDTH'(1);
  endfunction

  logic en;
  logic out_valid_q;

  assign en           = !out_valid_q || bus.out_ready;
  assign bus.in_ready = en;

  // Every level is carried at TREE_WIDTH; equivalent to growing one bit per level
  // because no partial sum can exceed the final tree range.
  for (genvar k = 0; k < STAGE_NUM; k++) begin : g_lvl
    localparam int NI = lvl_cnt(k);
    localparam int NO = lvl_cnt(k + 1);

    logic signed [TREE_WIDTH-1:0] opnd  [NI];
    logic signed [TREE_WIDTH-1:0] sum_d [NO];
    logic signed [TREE_WIDTH-1:0] sum_q [NO];
    logic vld_d, last_d, acc_en_d;
    logic vld_q, last_q, acc_en_q;

    if (k == 0) begin : g_src
      always_comb begin
        for (int i = 0; i < NI; i++) opnd[i] = sext_in(bus.in_data[i]);
      end
      assign vld_d    = bus.in_valid;
      assign last_d   = bus.in_last;
      assign acc_en_d = bus.in_acc_en;
    end else begin : g_chain
      always_comb begin
        for (int i = 0; i < NI; i++) opnd[i] = g_lvl[k-1].sum_q[i];
      end
      assign vld_d    = g_lvl[k-1].vld_q;
      assign last_d   = g_lvl[k-1].last_q;
      assign acc_en_d = g_lvl[k-1].acc_en_q;
    end

    for (genvar j = 0; j < NO; j++) begin : g_node
      if (2 * j + 1 < NI) begin : g_pair
        assign sum_d[j] = opnd[2*j] + opnd[2*j+1];
      end else begin : g_pass
        assign sum_d[j] = opnd[2*j];
      end
    end

    // ---- tree stage k register boundary ----
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int j = 0; j < NO; j++) sum_q[j] <= '0;
        vld_q    <= 1'b0;
        last_q   <= 1'b0;
        acc_en_q <= 1'b0;
      end else if (en) begin
        sum_q    <= sum_d;
        vld_q    <= vld_d;
        last_q   <= last_d;
        acc_en_q <= acc_en_d;
      end
    end
  end

  logic signed [TREE_WIDTH-1:0] tree_s;
  logic                         tree_vld, tree_last, tree_acc_en;

  assign tree_s      = g_lvl[STAGE_NUM-1].sum_q[0];
  assign tree_vld    = g_lvl[STAGE_NUM-1].vld_q;
  assign tree_last   = g_lvl[STAGE_NUM-1].last_q;
  assign tree_acc_en = g_lvl[STAGE_NUM-1].acc_en_q;

  acc_state_e                  state_q;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic [CNT_WIDTH-1:0]        cnt_q;
  logic signed [ACC_WIDTH-1:0] out_data_q;
  logic [CNT_WIDTH-1:0]        out_beats_q;

  logic signed [ACC_WIDTH-1:0] acc_sum;
  logic [CNT_WIDTH-1:0]        cnt_inc;

  always_comb begin
    acc_sum = sext_acc(tree_s);
    cnt_inc = sat_inc('0);
    if (state_q == PARTIAL) begin
      acc_sum = acc_q + sext_acc(tree_s);
      cnt_inc = sat_inc(cnt_q);
    end
  end

  // ---- accumulator / output register boundary ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= EMPTY;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_beats_q <= '0;
    end else if (en) begin
      if (!tree_vld) begin
        out_valid_q <= 1'b0;
      end else if (tree_acc_en && !tree_last) begin
        acc_q       <= acc_sum;
        cnt_q       <= cnt_inc;
        state_q     <= PARTIAL;
        out_valid_q <= 1'b0;
      end else begin
        out_data_q  <= acc_sum;
        out_beats_q <= cnt_inc;
        out_valid_q <= 1'b1;
        acc_q       <= '0;
        cnt_q       <= '0;
        state_q     <= EMPTY;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_beats = out_beats_q;

endmodule
